// File: rtl/data_memory_obi_slave_if.sv
// data_memory_obi_slave_if: LSU data-port bus between an LSU master and the data memory slave
interface data_memory_obi_slave_if;
    logic        data_req_o;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    modport master (
        output data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );
    modport slave (
        input  data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/data_memory_obi_slave.sv
// data_memory_obi_slave: byte-enable word memory with grant delay, in-order fixed-latency responses and store/load counters; DMEM_RANDOM_GNT_EN randomises the grant delay
module data_memory_obi_slave #(
    parameter int DEPTH_WORDS    = 1024,
    parameter int GNT_DELAY      = 0,
    parameter int RVALID_LATENCY = 1,
    parameter int OUTSTANDING    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    data_memory_obi_slave_if.slave  bus,
    output logic [31:0]             write_id,
    output logic [31:0]             read_id
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int WW = GNT_DELAY > 0 ? $clog2(GNT_DELAY + 1) : 1;
    localparam int OW = $clog2(OUTSTANDING + 1);

    logic [31:0]               r_mem [DEPTH_WORDS];
    logic [WW-1:0]             r_wait;
    logic [OW-1:0]             r_outst;
    logic [RVALID_LATENCY-1:0] r_pv;
    logic [31:0]               r_pd [RVALID_LATENCY];
    logic [WW-1:0]             w_thr;
    logic                      w_acc;
    logic [AW-1:0]             w_idx;
    logic                      w_unused;

    assign w_idx    = bus.data_addr_o[AW+1:2];
    assign w_unused = ^{bus.data_addr_o[31:AW+2], bus.data_addr_o[1:0]};
    // gnt is gated by rst_n so it drops the moment reset asserts
    assign bus.data_gnt_i    = rst_n && bus.data_req_o && (r_wait == w_thr) && (r_outst < OW'(OUTSTANDING));
    assign w_acc             = bus.data_req_o && bus.data_gnt_i;
    assign bus.data_rvalid_i = r_pv[RVALID_LATENCY-1];
    assign bus.data_rdata_i  = r_pd[RVALID_LATENCY-1];

`ifdef DMEM_RANDOM_GNT_EN
    logic [15:0]   r_lfsr;
    logic [WW-1:0] r_thr;
    logic [WW-1:0] w_rnd;

    assign w_rnd = WW'(32'(r_lfsr[3:0]) % (GNT_DELAY + 1));
    assign w_thr = (r_wait == '0) ? w_rnd : r_thr;

    // Free-running LFSR; a fresh threshold is captured when a request starts waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
            r_thr  <= '0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            if (bus.data_req_o && r_wait == '0) r_thr <= w_rnd;
        end
    end
`else
    assign w_thr = WW'(GNT_DELAY);
`endif

    // Grant-delay counter: counts held request cycles, restarts on idle or acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wait <= '0;
        else if (!bus.data_req_o || w_acc) r_wait <= '0;
        else if (r_wait < w_thr) r_wait <= r_wait + 1'b1;
    end

    // Outstanding count; a retirement in the same cycle as an acceptance nets to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_outst <= '0;
        else r_outst <= r_outst + OW'(w_acc) - OW'(bus.data_rvalid_i);
    end

    // Response shift register; load data is sampled at acceptance, stores respond with zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int i = 0; i < RVALID_LATENCY; i++) r_pd[i] <= '0;
        end else begin
            r_pv[0] <= w_acc;
            r_pd[0] <= (w_acc && !bus.data_we_o) ? r_mem[w_idx] : '0;
            for (int i = 1; i < RVALID_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    // Store path: byte-lane writes, storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_acc && bus.data_we_o)
            for (int i = 0; i < 4; i++)
                if (bus.data_be_o[i]) r_mem[w_idx][8*i +: 8] <= bus.data_wdata_o[8*i +: 8];
    end

    // Transaction ID counters for accepted stores and loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_id <= '0;
            read_id  <= '0;
        end else if (w_acc) begin
            if (bus.data_we_o) write_id <= write_id + 32'd1;
            else read_id <= read_id + 32'd1;
        end
    end
endmodule

// File: tb/tb_data_memory_obi_slave.sv
// tb_data_memory_obi_slave: directed and random traffic against a queue-based reference model
module tb_data_memory_obi_slave;
    localparam int DEPTH = 64;
    localparam int GD    = 1;
    localparam int LAT   = 6;
    localparam int OUTS  = 2;

    logic        clk = 0;
    logic        rst_n;
    logic [31:0] write_id, read_id;
    data_memory_obi_slave_if bus ();

    data_memory_obi_slave #(
        .DEPTH_WORDS(DEPTH), .GNT_DELAY(GD), .RVALID_LATENCY(LAT), .OUTSTANDING(OUTS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .write_id(write_id), .read_id(read_id)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] m_mem [DEPTH];
    int          mq_due [$];
    logic [31:0] mq_dat [$];
    int          m_wait, m_wr, m_rd;
    int          cap_cyc [$];
    logic [31:0] cap_dat [$];
    logic        e_gnt, e_rv;
    logic [31:0] e_rd;
    int          w, a;
    int          wt [4];
    int          ac [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: grant rule, due-time response queue, byte-merge memory, counters
    always @(negedge clk) begin
        if (!rst_n) begin
            mq_due.delete();
            mq_dat.delete();
            m_wait = 0;
            m_wr = 0;
            m_rd = 0;
            check("rst_gnt", {31'd0, bus.data_gnt_i}, 0);
            check("rst_rvalid", {31'd0, bus.data_rvalid_i}, 0);
            check("rst_rdata", bus.data_rdata_i, 0);
            check("rst_wid", write_id, 0);
            check("rst_rid", read_id, 0);
        end else begin
            e_gnt = bus.data_req_o && m_wait >= GD && mq_due.size() < OUTS;
            e_rv  = mq_due.size() > 0 && mq_due[0] == cyc;
            e_rd  = e_rv ? mq_dat[0] : 32'd0;
            check("gnt", {31'd0, bus.data_gnt_i}, {31'd0, e_gnt});
            check("rvalid", {31'd0, bus.data_rvalid_i}, {31'd0, e_rv});
            check("rdata", bus.data_rdata_i, e_rd);
            check("wid", write_id, m_wr);
            check("rid", read_id, m_rd);
            if (bus.data_rvalid_i) begin
                cap_cyc.push_back(cyc);
                cap_dat.push_back(bus.data_rdata_i);
            end
            if (e_rv) begin
                void'(mq_due.pop_front());
                void'(mq_dat.pop_front());
            end
            if (e_gnt) begin
                mq_due.push_back(cyc + LAT);
                mq_dat.push_back(bus.data_we_o ? 32'd0 : m_mem[bus.data_addr_o[7:2]]);
                if (bus.data_we_o) begin
                    for (int i = 0; i < 4; i++)
                        if (bus.data_be_o[i]) m_mem[bus.data_addr_o[7:2]][8*i +: 8] = bus.data_wdata_o[8*i +: 8];
                    m_wr++;
                end else m_rd++;
                m_wait = 0;
            end else m_wait = bus.data_req_o ? m_wait + 1 : 0;
        end
    end

    task automatic op(input logic we, input logic [31:0] ad, input logic [3:0] be, input logic [31:0] wd,
                      output int waited, output int acc);
        logic got = 0;
        waited = 0;
        acc = 0;
        bus.data_req_o = 1;
        bus.data_we_o = we;
        bus.data_addr_o = ad;
        bus.data_be_o = be;
        bus.data_wdata_o = wd;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            acc = cyc;
            if (bus.data_gnt_i) got = 1;
            else waited++;
        end
        if (!got) check("op_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.data_req_o = 0;
    endtask

    task automatic wait_caps(input int n);
        for (int i = 0; i < 200 && cap_dat.size() < n; i++) @(posedge clk);
        #1;
        check("resp_count", cap_dat.size(), n);
    endtask

    task automatic clear_caps();
        cap_cyc.delete();
        cap_dat.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        bus.data_req_o = 0;
        bus.data_we_o = 0;
        bus.data_addr_o = 0;
        bus.data_be_o = 0;
        bus.data_wdata_o = 0;
        rst_n = 1;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rvalid", {31'd0, bus.data_rvalid_i}, 0);
        check("reset_wid", write_id, 0);
        rst_n = 1;

        op(1, 32'h10, 4'hF, 32'hDEADBEEF, w, a);
        check("st_wait", w, GD);
        wait_caps(1);
        check("st_lat", cap_cyc[0] - a, LAT);
        check("st_rdata", cap_dat[0], 0);
        check("st_wid", write_id, 1);
        clear_caps();

        op(0, 32'h10, 4'h0, 0, w, a);
        wait_caps(1);
        check("ld_lat", cap_cyc[0] - a, LAT);
        check("ld_rdata", cap_dat[0], 32'hDEADBEEF);
        check("ld_rid", read_id, 1);
        clear_caps();

        op(1, 32'h10, 4'b0101, 32'h11223344, w, a);
        op(0, 32'h10, 4'h0, 0, w, a);
        op(0, 32'hFFFFFF12, 4'h0, 0, w, a);
        wait_caps(3);
        check("be_store_resp", cap_dat[0], 0);
        check("be_merge", cap_dat[1], 32'hDE22BE44);
        check("addr_wrap", cap_dat[2], 32'hDE22BE44);
        clear_caps();

        bus.data_req_o = 1;
        bus.data_we_o = 0;
        bus.data_addr_o = 32'h10;
        @(posedge clk);
        #1 bus.data_req_o = 0;
        @(posedge clk);
        #1;
        op(0, 32'h10, 4'h0, 0, w, a);
        check("restart_wait", w, GD);
        wait_caps(1);
        clear_caps();

        for (int i = 0; i < 4; i++) op(1, 32'h40 + 4 * i, 4'hF, 32'hA0000000 + i, w, a);
        wait_caps(4);
        clear_caps();
        for (int i = 0; i < 4; i++) op(0, 32'h40 + 4 * i, 4'h0, 0, wt[i], ac[i]);
        check("os_wait0", wt[0], 1);
        check("os_wait1", wt[1], 1);
        check("os_wait2", wt[2], 4);
        check("os_wait3", wt[3], 1);
        wait_caps(4);
        for (int i = 0; i < 4; i++) check("os_data", cap_dat[i], 32'hA0000000 + i);
        check("os_lat2", cap_cyc[2] - ac[2], LAT);
        clear_caps();

        op(0, 32'h40, 4'h0, 0, w, a);
        op(0, 32'h44, 4'h0, 0, w, a);
        rst_n = 0;
        #1;
        check("mid_rst_gnt", {31'd0, bus.data_gnt_i}, 0);
        check("mid_rst_rvalid", {31'd0, bus.data_rvalid_i}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check("post_rst_rid", read_id, 0);
        repeat (12) @(posedge clk);
        #1;
        check("no_late_rvalid", cap_dat.size(), 0);
        op(0, 32'h10, 4'h0, 0, w, a);
        wait_caps(1);
        check("mem_retained", cap_dat[0], 32'hDE22BE44);
        clear_caps();

        for (int n = 0; n < 250; n++) begin
            op($urandom_range(0, 1) == 1, ($urandom() & 32'hFFFFFF03) | ($urandom_range(0, 15) << 2),
               4'($urandom()), $urandom(), w, a);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (20) @(posedge clk);
        #1;
        check("drained", mq_due.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
